tp_tocador: RTL and testbench

- Transmitter counterpart of the note-sequence recognizer FSM.
- Takes a word request (type plus three root notes), then emits the word as a stream of note symbols over the same interface the recognizer consumes: ok strobe, tom, nota[2:0].
- Drives recognizer benches and on-board playback.
- Emits 5 notes followed by the terminator nota_x (000): 6 symbols per word.

---
 rtl/tp_tocador.sv | 163 ++++++++++++++++
 tb/tb_tp_tocador.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tp_tocador.sv
// Note-sequence transmitter: turns a word request (type + three roots) into a
// stream of six (ok, tom, nota) symbols ending in the nota_x terminator.
module tp_tocador #(
  parameter int GAP     = 1,  // ok-low cycles after each accepted symbol, 0..15
  parameter int TIMEOUT = 0   // max SEND cycles waiting for ready; 0 disables
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] tipo_in,
  input  logic [8:0] raiz,
  input  logic       cancel,
  input  logic       ready,
  output logic       ok,
  output logic       tom,
  output logic [2:0] nota,
  output logic       busy,
  output logic       fim,
  output logic       erro
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_FIM} state_t;

  localparam logic [2:0]  NOTA_X   = 3'b000;
  localparam logic [2:0]  NOTA_DO  = 3'b001;
  localparam logic [2:0]  NOTA_FA  = 3'b100;
  localparam logic [2:0]  NOTA_LA  = 3'b110;
  localparam logic [2:0]  NOTA_SI  = 3'b111;
  localparam logic [1:0]  TIPO_ADJ  = 2'b01;
  localparam logic [1:0]  TIPO_COMP = 2'b10;
  localparam logic [2:0]  LAST_IDX = 3'd5;
  localparam logic [3:0]  GAP_LAST = 4'(GAP - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  tipo_q;
  logic [8:0]  raiz_q;
  logic [2:0]  idx;
  logic [3:0]  gap_cnt;
  logic [15:0] wait_cnt;

  logic [2:0]  idx_nxt;
  logic        req_ok;
  logic        timeout_hit;

  // Returns {nota, tom} for symbol i of a word: three roots, a type suffix, terminator.
  function automatic logic [3:0] symbol(input logic [2:0] i, input logic [1:0] t,
                                        input logic [8:0] r);
    logic [3:0] s;
    s = {NOTA_X, 1'b0};
    case (i)
      3'd0: s = {r[8:6], 1'b1};
      3'd1: s = {r[5:3], 1'b1};
      3'd2: s = {r[2:0], 1'b1};
      3'd3: s = (t == TIPO_ADJ) ? {NOTA_FA, 1'b1} : {NOTA_LA, 1'b0};
      3'd4: begin
        case (t)
          TIPO_ADJ:  s = {NOTA_LA, 1'b0};
          TIPO_COMP: s = {NOTA_DO, 1'b1};
          default:   s = {NOTA_SI, 1'b0};
        endcase
      end
      default: s = {NOTA_X, 1'b0};
    endcase
    return s;
  endfunction

  assign idx_nxt     = idx + 3'd1;
  assign req_ok      = (tipo_in != 2'b00) && (raiz[8:6] != NOTA_X) &&
                       (raiz[5:3] != NOTA_X) && (raiz[2:0] != NOTA_X);
  assign timeout_hit = (TIMEOUT > 0) && !ready && (wait_cnt == TO_LAST);

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would leak new values into later lines.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      tipo_q   <= 2'b00;
      raiz_q   <= 9'd0;
      idx      <= 3'd0;
      gap_cnt  <= 4'd0;
      wait_cnt <= 16'd0;
      ok       <= 1'b0;
      tom      <= 1'b0;
      nota     <= NOTA_X;
      busy     <= 1'b0;
      fim      <= 1'b0;
      erro     <= 1'b0;
    end else begin
      fim  <= 1'b0;
      erro <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (req_ok) begin
              tipo_q      <= tipo_in;
              raiz_q      <= raiz;
              idx         <= 3'd0;
              wait_cnt    <= 16'd0;
              state       <= ST_SEND;
              ok          <= 1'b1;
              busy        <= 1'b1;
              {nota, tom} <= symbol(3'd0, tipo_in, raiz);
            end else begin
              erro <= 1'b1;
            end
          end
        end

        ST_SEND: begin
          // cancel outranks both accept and timeout in the same cycle
          if (cancel || timeout_hit) begin
            state <= ST_IDLE;
            ok    <= 1'b0;
            busy  <= 1'b0;
            nota  <= NOTA_X;
            tom   <= 1'b0;
            erro  <= !cancel;
          end else if (ready) begin
            wait_cnt <= 16'd0;
            if (idx == LAST_IDX) begin
              state <= ST_FIM;
              fim   <= 1'b1;
              busy  <= 1'b0;
              ok    <= 1'b0;
              nota  <= NOTA_X;
              tom   <= 1'b0;
            end else if (GAP == 0) begin
              idx         <= idx_nxt;
              {nota, tom} <= symbol(idx_nxt, tipo_q, raiz_q);
            end else begin
              state   <= ST_GAP;
              ok      <= 1'b0;
              gap_cnt <= 4'd0;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        ST_GAP: begin
          if (cancel) begin
            state <= ST_IDLE;
            ok    <= 1'b0;
            busy  <= 1'b0;
            nota  <= NOTA_X;
            tom   <= 1'b0;
          end else if (gap_cnt == GAP_LAST) begin
            state       <= ST_SEND;
            idx         <= idx_nxt;
            ok          <= 1'b1;
            {nota, tom} <= symbol(idx_nxt, tipo_q, raiz_q);
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end

        default: state <= ST_IDLE;  // ST_FIM: one cycle, start ignored
      endcase
    end
  end

endmodule

// File: tb/tb_tp_tocador.sv
// Bench for tp_tocador: two instances (GAP=0/no timeout, GAP=2/TIMEOUT=4) checked
// every cycle against a word-level reference model, plus directed literal checks.
module tb_tp_tocador;

  logic       clk = 1'b0;
  logic       reset;
  logic       start = 1'b0, cancel = 1'b0, ready = 1'b1;
  logic [1:0] tipo_in = 2'b00;
  logic [8:0] raiz = 9'd0;

  logic [1:0] ok_w, tom_w, busy_w, fim_w, erro_w;
  logic [2:0] nota_w [2];

  int n_checks = 0;
  int n_fail   = 0;

  tp_tocador #(.GAP(0), .TIMEOUT(0)) u0 (
    .clk(clk), .reset(reset), .start(start), .tipo_in(tipo_in), .raiz(raiz),
    .cancel(cancel), .ready(ready), .ok(ok_w[0]), .tom(tom_w[0]), .nota(nota_w[0]),
    .busy(busy_w[0]), .fim(fim_w[0]), .erro(erro_w[0]));

  tp_tocador #(.GAP(2), .TIMEOUT(4)) u1 (
    .clk(clk), .reset(reset), .start(start), .tipo_in(tipo_in), .raiz(raiz),
    .cancel(cancel), .ready(ready), .ok(ok_w[1]), .tom(tom_w[1]), .nota(nota_w[1]),
    .busy(busy_w[1]), .fim(fim_w[1]), .erro(erro_w[1]));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (word level) ----------------
  localparam int GAPV [2] = '{0, 2};
  localparam int TOV  [2] = '{0, 4};

  bit         m_act  [2] = '{0, 0};
  int         m_idx  [2] = '{0, 0};
  int         m_gap  [2] = '{0, 0};
  int         m_wait [2] = '{0, 0};
  logic [2:0] m_nota [2] = '{3'd0, 3'd0};
  logic       m_tom  [2] = '{1'b0, 1'b0};
  logic       m_fim  [2] = '{1'b0, 1'b0};
  logic       m_erro [2] = '{1'b0, 1'b0};
  logic [3:0] m_syms [2][6];

  function automatic logic [3:0] suffix(input logic [1:0] t, input int k);
    // adj: fa/1 la/0, comp: la/0 do/1, adv: la/0 si/0  -> {nota,tom}
    if (k == 0) return (t == 2'b01) ? 4'b1001 : 4'b1100;
    if (t == 2'b01) return 4'b1100;
    if (t == 2'b10) return 4'b0011;
    return 4'b1110;
  endfunction

  task automatic present(input int i);
    m_nota[i] = m_syms[i][m_idx[i]][3:1];
    m_tom[i]  = m_syms[i][m_idx[i]][0];
  endtask

  task automatic go_idle(input int i);
    m_act[i]  = 0;
    m_nota[i] = 3'd0;
    m_tom[i]  = 1'b0;
  endtask

  task automatic model_step(input int i);
    logic was_fim;
    was_fim   = m_fim[i];
    m_fim[i]  = 1'b0;
    m_erro[i] = 1'b0;
    if (m_act[i]) begin
      if (cancel) go_idle(i);
      else if (m_gap[i] > 0) begin
        m_gap[i]--;
        if (m_gap[i] == 0) begin m_idx[i]++; present(i); end
      end else if (ready) begin
        m_wait[i] = 0;
        if (m_idx[i] == 5) begin go_idle(i); m_fim[i] = 1'b1; end
        else if (GAPV[i] == 0) begin m_idx[i]++; present(i); end
        else m_gap[i] = GAPV[i];
      end else begin
        m_wait[i]++;
        if (TOV[i] > 0 && m_wait[i] == TOV[i]) begin go_idle(i); m_erro[i] = 1'b1; end
      end
    end else if (!was_fim && start) begin
      if (tipo_in == 2'b00 || raiz[8:6] == 0 || raiz[5:3] == 0 || raiz[2:0] == 0)
        m_erro[i] = 1'b1;
      else begin
        m_syms[i][0] = {raiz[8:6], 1'b1};
        m_syms[i][1] = {raiz[5:3], 1'b1};
        m_syms[i][2] = {raiz[2:0], 1'b1};
        m_syms[i][3] = suffix(tipo_in, 0);
        m_syms[i][4] = suffix(tipo_in, 1);
        m_syms[i][5] = 4'b0000;
        m_act[i] = 1; m_idx[i] = 0; m_gap[i] = 0; m_wait[i] = 0;
        present(i);
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        go_idle(i);
        m_gap[i] = 0; m_wait[i] = 0; m_idx[i] = 0;
        m_fim[i] = 1'b0; m_erro[i] = 1'b0;
      end else begin
        model_step(i);
      end
    end
  end

  // ---------------- per-cycle compare and stream monitor ----------------
  bit cmp_en = 1'b0;
  int cyc = 0, st_cyc = 0, fim_cyc0 = 0, fim_cyc1 = 0;
  logic [3:0] q0 [$];
  logic [3:0] q1 [$];

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++)
        check($sformatf("dut%0d ok,tom,nota,busy,fim,erro", i),
              {ok_w[i], tom_w[i], nota_w[i], busy_w[i], fim_w[i], erro_w[i]},
              {(m_act[i] && m_gap[i] == 0), m_tom[i], m_nota[i], m_act[i], m_fim[i], m_erro[i]});
    end
    cyc++;
    if (ok_w[0] && ready) q0.push_back({nota_w[0], tom_w[0]});
    if (ok_w[1] && ready) q1.push_back({nota_w[1], tom_w[1]});
    if (fim_w[0]) fim_cyc0 = cyc;
    if (fim_w[1]) fim_cyc1 = cyc;
    if (start) st_cyc = cyc;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(input logic [1:0] t, input logic [8:0] r);
    start = 1'b1; tipo_in = t; raiz = r;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_quiet(input int bound);
    int k = 0;
    while ((busy_w != 2'b00 || fim_w != 2'b00) && k < bound) begin tick(1); k++; end
    check("wait_quiet bound", k < bound, 1);
  endtask

  localparam logic [8:0] ROOTS = 9'b001_010_011;
  logic [3:0] adj_exp [6] = '{4'b0011, 4'b0101, 4'b0111, 4'b1001, 4'b1100, 4'b0000};

  initial begin
    int n_ok, k;
    reset = 1'b0;
    #1 cmp_en = 1'b1;
    tick(3);
    check("reset outs dut0", {ok_w[0], busy_w[0], fim_w[0], erro_w[0], nota_w[0]}, 0);
    check("reset outs dut1", {ok_w[1], busy_w[1], fim_w[1], erro_w[1], nota_w[1]}, 0);
    reset = 1'b1;
    tick(2);

    // adj word, ready high
    q0.delete(); q1.delete();
    pulse_start(2'b01, ROOTS);
    wait_quiet(40);
    check("adj len dut0", q0.size(), 6);
    check("adj len dut1", q1.size(), 6);
    if (q0.size() == 6 && q1.size() == 6)
      for (int j = 0; j < 6; j++) begin
        check($sformatf("adj sym%0d dut0", j), q0[j], adj_exp[j]);
        check($sformatf("adj sym%0d dut1", j), q1[j], adj_exp[j]);
      end
    check("adj fim latency gap0", fim_cyc0 - st_cyc, 7);
    check("adj fim latency gap2", fim_cyc1 - st_cyc, 17);

    // comp and adv suffixes
    for (int w = 2; w <= 3; w++) begin
      q1.delete();
      pulse_start(2'(w), ROOTS);
      wait_quiet(40);
      check("suffix len", q1.size(), 6);
      if (q1.size() == 6) begin
        check("suffix sym3", q1[3], 4'b1100);
        check("suffix sym4", q1[4], (w == 2) ? 4'b0011 : 4'b1110);
      end
    end

    // back-pressure on index 2 of dut0
    q0.delete();
    pulse_start(2'b01, ROOTS);
    tick(2);
    ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp hold ok,nota", {ok_w[0], nota_w[0]}, 4'b1011);
      @(posedge clk); #1;
    end
    ready = 1'b1;
    wait_quiet(60);
    check("bp len", q0.size(), 6);

    // rejected requests
    pulse_start(2'b00, ROOTS);
    check("reject tipo erro,ok,busy", {erro_w, ok_w, busy_w}, 6'b11_00_00);
    tick(1);
    pulse_start(2'b01, 9'b000_010_011);
    check("reject raiz erro,ok,busy", {erro_w, ok_w, busy_w}, 6'b11_00_00);
    tick(1);

    // timeout on dut1, then cancel the stalled dut0
    ready = 1'b0;
    pulse_start(2'b01, ROOTS);
    n_ok = 0; k = 0;
    while (!erro_w[1] && k < 20) begin
      if (ok_w[1]) n_ok++;
      tick(1); k++;
    end
    check("timeout ok cycles", n_ok, 4);
    check("timeout erro,ok,busy,fim", {erro_w[1], ok_w[1], busy_w[1], fim_w[1]}, 4'b1000);
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    ready  = 1'b1;
    check("cancel stalled ok,busy,fim,erro", {ok_w[0], busy_w[0], fim_w[0], erro_w[0]}, 0);
    wait_quiet(20);

    // cancel at index 3 of dut0
    pulse_start(2'b01, ROOTS);
    tick(3);
    check("pre-cancel ok,nota,tom", {ok_w[0], nota_w[0], tom_w[0]}, 5'b1_100_1);
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    check("cancel idx3 ok,busy,fim,erro,nota", {ok_w[0], busy_w[0], fim_w[0], erro_w[0], nota_w[0]}, 0);
    wait_quiet(40);

    // async reset while dut1 sits in its gap
    pulse_start(2'b10, ROOTS);
    tick(1);
    check("pre-reset dut1 ok,busy", {ok_w[1], busy_w[1]}, 2'b01);
    #2 reset = 1'b0;
    #1;
    check("async reset dut0", {ok_w[0], tom_w[0], nota_w[0], busy_w[0], fim_w[0], erro_w[0]}, 0);
    check("async reset dut1", {ok_w[1], tom_w[1], nota_w[1], busy_w[1], fim_w[1], erro_w[1]}, 0);
    tick(2);
    reset = 1'b1;
    tick(1);
    q0.delete(); q1.delete();
    pulse_start(2'b01, ROOTS);
    wait_quiet(40);
    check("post-reset len dut0", q0.size(), 6);
    check("post-reset len dut1", q1.size(), 6);
    if (q0.size() > 0) check("post-reset first sym", q0[0], 4'b0011);

    // randomized traffic, checked by the per-cycle compare
    for (int c = 0; c < 600; c++) begin
      ready   = ($urandom_range(0, 3) != 0);
      cancel  = ($urandom_range(0, 49) == 0);
      start   = ($urandom_range(0, 5) == 0);
      tipo_in = 2'($urandom_range(0, 3));
      raiz    = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
      tick(1);
    end
    start = 1'b0; cancel = 1'b0; ready = 1'b1;
    wait_quiet(100);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
